shift_unit_seq: RTL and testbench
=================================

Name: shift_unit_seq

Overview:
Multi-cycle shifter in the EX stage. It executes SLL/SRL/SRA (and their variable forms) on a 32-bit operand. The shift amount arrives as a 32-bit zero-extended value, taken either from the shamt zero-extender (instr[10:6]) or from rs. The block shifts STEP bits per cycle under a start/busy/done handshake, and the pipeline stalls on busy.

Parameters:
STEP, 4, bits shifted per SHIFT cycle; legal values 1, 2, 4, 8, 16.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when accepted
op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved
operand  input  32  value to shift (rt)
shamt  input  32  zero-extended shift amount; only [4:0] used
flush  input  1  synchronous abort from hazard/exception logic
busy  output  1  high while a shift is in progress
done  output  1  one-cycle pulse when result is valid
result  output  32  shifted value; held until the next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, result=0, remaining=0, sign=0. Asynchronous assertion mid-shift drops everything immediately; no partial result survives.
- States:
  - IDLE: waiting for a request.
  - SHIFT: shifting in progress.
  - DONE: result presented.
- Acceptance: start is accepted when state is IDLE or DONE and flush=0. start in SHIFT is ignored (no queueing).
- On accept:
  - acc<=operand, remaining<=shamt[4:0], sign<=operand[31], opr<=op.
  - Bits shamt[31:5] are ignored, so 0x20 means a shift of 0.
  - If remaining==0 or op==11, go to DONE with result=operand.
  - Otherwise go to SHIFT.
- SHIFT, each cycle:
  - k = min(STEP, remaining); acc shifted by k.
  - SLL fills with 0, SRL fills with 0, SRA fills with the latched sign.
  - remaining -= k.
  - When remaining reaches 0, result<=shifted acc and the state moves to DONE.
- Latency, with the accepting edge as cycle 0:
  - done is high in cycle 1 for n=0.
  - done is high in cycle 1+ceil(n/STEP) for n>0.
- busy is registered: high exactly in SHIFT cycles, low in IDLE and DONE.
- DONE lasts one cycle: done=1, then IDLE. A start accepted in the DONE cycle begins the next operation back-to-back, with no idle bubble.
- flush:
  - Any state goes to IDLE on the next edge; busy=0, done=0. A done pulse due in that cycle is suppressed.
  - result keeps its previous value.
  - flush and start together: flush wins and start is dropped.
- Width rules:
  - All arithmetic is 32-bit.
  - remaining is 5 bits and never underflows, because k ≤ remaining.
  - A shift by 31 is legal.

Decomposition:
- Package mips_shift_pkg holds:
  - op localparams SHOP_SLL=2'b00, SHOP_SRL=2'b01, SHOP_SRA=2'b10, SHOP_RSV=2'b11;
  - state encoding ST_IDLE, ST_SHIFT, ST_DONE;
  - SHAMT_W=5.
- One combinational sub-module, shift_step:
  - inputs: 32-bit data, amount k (0..STEP), op, sign;
  - output: the shifted data.
  - Instantiated once inside the SHIFT datapath.
- The FSM, counter and handshake stay in shift_unit_seq.

Test Plan:
- STEP=4, SLL, operand=0x00000001, shamt=0x0000001F -> busy for 8 cycles; done in cycle 9; result=0x80000000.
- STEP=4, SRA, operand=0x80000000, shamt=4 -> done in cycle 2; result=0xF8000000. Repeat with operand=0x7FFFFFF0 -> 0x07FFFFFF.
- STEP=4, SRL, operand=0x80000000, shamt=5 -> shifts of 4 then 1; done in cycle 3; result=0x04000000. Then start again in the DONE cycle with SLL by 1 -> second done in cycle 5 (two cycles after that accept), no bubble; result=0x00000002.
- shamt=0x00000020 and, separately, op=11 with shamt=7, operand=0x12345678 -> each: done in cycle 1, busy never high, result=0x12345678.
- SLL operand=0x1, shamt=31, with these injections:
  - start pulsed in cycle 3 -> ignored;
  - flush in cycle 4 -> busy=0 and state IDLE in cycle 5, no done pulse, result unchanged;
  - flush and start in the same cycle -> nothing accepted.
- rst_n asserted mid-SHIFT (between edges) -> busy, done and result are 0 immediately. After release, SRL operand=0xF0000000, shamt=8 -> result=0x00F00000 in cycle 3.

Source files
------------

// File: rtl/mips_shift_pkg.sv
// Shared encodings for the multi-cycle EX-stage shifter.
package mips_shift_pkg;

    // Shift operation codes as they arrive from decode.
    localparam logic [1:0] SHOP_SLL = 2'b00;
    localparam logic [1:0] SHOP_SRL = 2'b01;
    localparam logic [1:0] SHOP_SRA = 2'b10;
    localparam logic [1:0] SHOP_RSV = 2'b11;

    // Only the low five bits of the amount are used. This is enough for 0..31.
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One combinational shift slice: moves data by 'amount' bits in the direction and
// fill mode chosen by op. SRA fills with the operand sign latched at accept.
module shift_step
    import mips_shift_pkg::*;
(
    input  logic [31:0]        data,
    input  logic [SHAMT_W-1:0] amount,
    input  logic [1:0]         op,
    input  logic               sign,
    output logic [31:0]        shifted
);

    logic [31:0] vacated;

    // Select the shifted word and the fill for the vacated upper bits on right shifts.
    always_comb begin
        // NOTE: the output gets a default before the case. Because of that, no path leaves it unassigned, and no latch is inferred.
        shifted = data;
        vacated = ~(32'hFFFF_FFFF >> amount);
        case (op)
            SHOP_SLL: shifted = data << amount;
            SHOP_SRL: shifted = data >> amount;
            SHOP_SRA: shifted = (data >> amount) | ({32{sign}} & vacated);
            default:  shifted = data;
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter. It takes up to STEP bits per cycle and uses a start/busy/done
// handshake. The pipeline stalls while busy is high. flush aborts the operation without touching result.
module shift_unit_seq
    import mips_shift_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand,
    input  logic [31:0] shamt,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

    state_t             state, state_nxt;
    logic [31:0]        acc;
    logic [SHAMT_W-1:0] remaining;
    logic               sign;
    logic [1:0]         opr;

    logic               accept;
    logic               accept_trivial;
    logic               last_step;
    logic [SHAMT_W-1:0] step_k;
    logic [31:0]        acc_shifted;

    // Amount bits above [4:0] are architecturally ignored.
    logic               unused_shamt_hi;
    assign unused_shamt_hi = |shamt[31:SHAMT_W];

    // A new request is taken only between operations, and a concurrent flush always wins.
    assign accept         = start && !flush && (state == ST_IDLE || state == ST_DONE);
    assign accept_trivial = (shamt[SHAMT_W-1:0] == '0) || (op == SHOP_RSV);

    // This cycle's shift amount is min(STEP, remaining), so remaining can never underflow.
    assign step_k    = (remaining < STEP_K) ? remaining : STEP_K;
    assign last_step = (remaining == step_k);

    shift_step u_shift_step (
        .data    (acc),
        .amount  (step_k),
        .op      (opr),
        .sign    (sign),
        .shifted (acc_shifted)
    );

    // Next-state logic: IDLE/DONE wait for accept, SHIFT runs until the count is used up. flush overrides everything.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                state_nxt = ST_IDLE;
                if (accept)
                    state_nxt = accept_trivial ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_step)
                    state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (flush)
            state_nxt = ST_IDLE;
    end

    // State register, plus busy/done registered from the next state so that they are clean flop outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is always assigned with <=. This way every flop samples values from before the edge.
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == ST_SHIFT);
            done  <= (state_nxt == ST_DONE);
        end
    end

    // Datapath: latch the operands on accept, then step the accumulator and count down in SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            remaining <= '0;
            sign      <= 1'b0;
            opr       <= SHOP_SLL;
            result    <= '0;
        end else if (accept) begin
            acc       <= operand;
            remaining <= shamt[SHAMT_W-1:0];
            sign      <= operand[31];
            opr       <= op;
            if (accept_trivial)
                result <= operand;
        end else if (state == ST_SHIFT && !flush) begin
            acc       <= acc_shifted;
            remaining <= remaining - step_k;
            if (last_step)
                result <= acc_shifted;
        end
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq. A reference model computes the expected result
// with plain shift operators and the latency as 1 + ceil(n/STEP).
module tb_shift_unit_seq;

    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand;
    logic [31:0] shamt;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_result = '0;

    always #5 clk = ~clk;

    shift_unit_seq #(.STEP(STEP)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .operand (operand),
        .shamt   (shamt),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    function automatic logic [31:0] model_result(input logic [1:0] o, input logic [31:0] a,
                                                 input logic [31:0] s);
        int n = int'(s % 32);
        case (o)
            2'b00:   return a << n;
            2'b01:   return a >> n;
            2'b10:   return $unsigned($signed(a) >>> n);
            default: return a;
        endcase
    endfunction

    function automatic int model_latency(input logic [1:0] o, input logic [31:0] s);
        int n = int'(s % 32);
        if (n == 0 || o == 2'b11) return 1;
        return 1 + (n + STEP - 1) / STEP;
    endfunction

    // Starts one operation and checks busy/done every cycle until the done pulse and the result.
    // It returns at the negedge of the DONE cycle, so the caller may chain a back-to-back start.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] s,
                          input string name);
        logic [31:0] exp_res = model_result(o, a, s);
        int          lat     = model_latency(o, s);
        op = o; operand = a; shamt = s; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; operand = $urandom; shamt = $urandom; op = 2'($urandom_range(0, 3));
        for (int cyc = 1; cyc <= lat; cyc++) begin
            checks++;
            if (busy !== (cyc < lat)) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b want %b", name, cyc, busy, (cyc < lat));
            end
            checks++;
            if (done !== (cyc == lat)) begin
                errors++;
                $display("FAIL %s done cycle %0d: got %b want %b", name, cyc, done, (cyc == lat));
            end
            if (cyc < lat) @(negedge clk);
        end
        checks++;
        if (result !== exp_res) begin
            errors++;
            $display("FAIL %s result: got %08h want %08h", name, result, exp_res);
        end
        last_result = exp_res;
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: got busy=%b done=%b want 0 0", name, busy, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; operand = '0; shamt = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_hold: got busy=%b done=%b result=%08h want 0 0 00000000",
                     busy, done, result);
        end
        rst_n = 1'b1;
        idle_check("reset_release");
        checks++;
        if (result !== 32'h0) begin
            errors++;
            $display("FAIL reset_result: got %08h want 00000000", result);
        end
    endtask

    task automatic test_directed();
        run_op(2'b00, 32'h0000_0001, 32'h0000_001F, "sll31");
        idle_check("done_one_cycle");
        run_op(2'b10, 32'h8000_0000, 32'd4, "sra_neg4");
        idle_check("sra_neg4_after");
        run_op(2'b10, 32'h7FFF_FFF0, 32'd4, "sra_pos4");
        idle_check("sra_pos4_after");
        run_op(2'b00, 32'h1234_5678, 32'h0000_0020, "shamt_0x20");
        idle_check("shamt_0x20_after");
        run_op(2'b11, 32'h1234_5678, 32'd7, "op_reserved");
        idle_check("op_reserved_after");
    endtask

    task automatic test_back_to_back();
        run_op(2'b01, 32'h8000_0000, 32'd5, "b2b_srl5");
        run_op(2'b00, 32'h0000_0001, 32'd1, "b2b_sll1");
        idle_check("b2b_after");
    endtask

    task automatic test_flush();
        op = 2'b00; operand = 32'h0000_0001; shamt = 32'd31; start = 1'b1;
        @(posedge clk);
        @(negedge clk);                       // cycle 1
        start = 1'b0;
        @(negedge clk);                       // cycle 2
        @(negedge clk);                       // cycle 3: a stray start must be ignored
        start = 1'b1; op = 2'b00; operand = 32'hABCD_0000; shamt = 32'd0;
        @(negedge clk);                       // cycle 4
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_in_shift: got busy=%b done=%b want 1 0", busy, done);
        end
        flush = 1'b1;
        @(negedge clk);                       // cycle 5
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== last_result) begin
            errors++;
            $display("FAIL flush_abort: got busy=%b done=%b result=%08h want 0 0 %08h",
                     busy, done, result, last_result);
        end
        for (int i = 0; i < 10; i++) idle_check("flush_no_done");
        start = 1'b1; flush = 1'b1; op = 2'b00; operand = 32'hABCD_0000; shamt = 32'd0;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || result !== last_result) begin
                errors++;
                $display("FAIL flush_start: got busy=%b done=%b result=%08h want 0 0 %08h",
                         busy, done, result, last_result);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        op = 2'b01; operand = 32'hFFFF_FFFF; shamt = 32'd31; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: got busy=%b want 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL areset_now: got busy=%b done=%b result=%08h want 0 0 00000000",
                     busy, done, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_result = '0;
        @(negedge clk);
        run_op(2'b01, 32'hF000_0000, 32'd8, "post_reset_srl8");
        idle_check("post_reset_after");
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, s;
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            s = $urandom;
            if ($urandom_range(0, 3) == 0) s = 32'($urandom_range(0, 31));
            run_op(o, a, s, "random");
            if ($urandom_range(0, 1) == 0) idle_check("random_idle");
        end
        idle_check("random_end");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
